// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, drives the imem request,
// passes returned words straight through to IF/ID, and parks one word in a
// hold buffer when a downstream stall arrives together with an ihit.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] npc_out,
    output logic [31:0] instr_out,
    output logic        valid_out,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buf_instr;
    logic [31:0] buf_npc;
    logic [31:0] tgt;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;

    // PC, hold buffer, pending redirect target and fetch state; redirect wins over everything.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= FETCH;
            pc        <= PC_INIT;
            buf_instr <= '0;
            buf_npc   <= '0;
            tgt       <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        if (ihit) begin
                            pc <= redirect_pc;
                        end else begin
                            // request still in flight: keep address, remember target
                            tgt   <= redirect_pc;
                            state <= SQUASH;
                        end
                    end else if (ihit) begin
                        pc <= pc_plus4;
                        if (stall) begin
                            buf_instr <= imemload;
                            buf_npc   <= pc_plus4;
                            state     <= HOLD;
                        end else if (imemload[31:26] == HALT_OP) begin
                            state <= HALTED;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= redirect_pc;
                        state <= FETCH;
                    end else if (!stall) begin
                        state <= (buf_instr[31:26] == HALT_OP) ? HALTED : FETCH;
                    end
                end
                SQUASH: begin
                    if (ihit) begin
                        pc    <= redirect ? redirect_pc : tgt;
                        state <= FETCH;
                    end else if (redirect) begin
                        tgt <= redirect_pc;
                    end
                end
                HALTED: begin
                    if (redirect) begin
                        pc    <= redirect_pc;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Output decode per state, forced to zero combinationally while in reset.
    always_comb begin
        imemREN   = 1'b0;
        imemaddr  = '0;
        npc_out   = '0;
        instr_out = '0;
        valid_out = 1'b0;
        halted    = 1'b0;
        if (nRST) begin
            imemaddr = pc;
            case (state)
                FETCH: begin
                    imemREN   = 1'b1;
                    instr_out = imemload;
                    npc_out   = pc_plus4;
                    valid_out = ihit && !redirect;
                end
                HOLD: begin
                    instr_out = buf_instr;
                    npc_out   = buf_npc;
                    valid_out = !redirect;
                end
                SQUASH: begin
                    imemREN   = 1'b1;
                    instr_out = imemload;
                    npc_out   = pc_plus4;
                end
                HALTED: begin
                    halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with literal expectations, then randomized
// ihit/stall/redirect/reset traffic checked every cycle against a reference model.
module tb_fetch_unit;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] npc_out;
    logic [31:0] instr_out;
    logic        valid_out;
    logic        halted;

    int vectors;
    int miscompares;

    // reference model state
    logic [31:0] m_pc;
    logic        m_buf_full;
    logic [31:0] m_buf_w;
    logic [31:0] m_buf_n;
    logic        m_squash;
    logic [31:0] m_tgt;
    logic        m_halted;

    logic [31:0] halt_at;
    logic        rand_halts;

    fetch_unit #(.PC_INIT(32'h0000_0000), .HALT_OP(6'b111111)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .ihit(ihit),
        .imemload(imemload),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imemREN(imemREN),
        .imemaddr(imemaddr),
        .npc_out(npc_out),
        .instr_out(instr_out),
        .valid_out(valid_out),
        .halted(halted)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // instruction memory contents as a function of address
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == halt_at) return 32'hFC00_0000;
        if (rand_halts && a[6:2] == 5'd19) return {6'b111111, a[25:0]};
        return {6'b000100, a[25:0]};
    endfunction

    function automatic logic is_halt(input logic [31:0] w);
        return w[31:26] == 6'b111111;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc       = 32'h0;
        m_buf_full = 1'b0;
        m_buf_w    = 32'h0;
        m_buf_n    = 32'h0;
        m_squash   = 1'b0;
        m_tgt      = 32'h0;
        m_halted   = 1'b0;
    endtask

    // advance the model by one clock edge using the inputs held during the cycle
    task automatic model_update();
        if (!nRST) begin
            model_reset();
        end else if (redirect) begin
            if (!m_halted && !m_buf_full && !ihit) begin
                m_squash = 1'b1;
                m_tgt    = redirect_pc;
            end else begin
                m_pc       = redirect_pc;
                m_buf_full = 1'b0;
                m_squash   = 1'b0;
                m_halted   = 1'b0;
            end
        end else if (m_halted) begin
        end else if (m_buf_full) begin
            if (!stall) begin
                m_buf_full = 1'b0;
                if (is_halt(m_buf_w)) m_halted = 1'b1;
            end
        end else if (m_squash) begin
            if (ihit) begin
                m_pc     = m_tgt;
                m_squash = 1'b0;
            end
        end else if (ihit) begin
            if (stall) begin
                m_buf_full = 1'b1;
                m_buf_w    = imemload;
                m_buf_n    = m_pc + 32'd4;
            end else if (is_halt(imemload)) begin
                m_halted = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end
    endtask

    // compare every DUT output against what the model says this cycle
    task automatic check_model();
        logic        e_ren, e_valid, e_halted;
        logic [31:0] e_addr, e_instr, e_npc;
        e_ren = 1'b0; e_valid = 1'b0; e_halted = 1'b0;
        e_addr = 32'h0; e_instr = 32'h0; e_npc = 32'h0;
        if (nRST) begin
            e_addr = m_pc;
            if (m_halted) begin
                e_halted = 1'b1;
            end else if (m_buf_full) begin
                e_instr = m_buf_w;
                e_npc   = m_buf_n;
                e_valid = !redirect;
            end else if (m_squash) begin
                e_ren = 1'b1;
            end else begin
                e_ren   = 1'b1;
                e_instr = imemload;
                e_npc   = m_pc + 32'd4;
                e_valid = ihit && !redirect;
            end
        end
        chk("imemREN", {31'b0, imemREN}, {31'b0, e_ren});
        chk("imemaddr", imemaddr, e_addr);
        chk("valid_out", {31'b0, valid_out}, {31'b0, e_valid});
        chk("halted", {31'b0, halted}, {31'b0, e_halted});
        if (e_valid || !nRST) begin
            chk("instr_out", instr_out, e_instr);
            chk("npc_out", npc_out, e_npc);
        end
    endtask

    // one cycle: model takes the edge, new inputs driven at negedge, outputs checked
    task automatic tick(input logic rst_v, input logic i, input logic s,
                        input logic r, input logic [31:0] rp);
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        nRST        = rst_v;
        ihit        = i;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        if (!rst_v) model_reset();
        imemload = i ? mem(m_pc) : $urandom;
        #1;
        check_model();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        halt_at     = 32'hFFFF_FFFF;
        rand_halts  = 1'b0;
        nRST        = 1'b0;
        ihit        = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imemload    = 32'h0;
        model_reset();

        // reset state
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_ren", {31'b0, imemREN}, 32'h0);
        chk("rst_valid", {31'b0, valid_out}, 32'h0);

        // 1: streaming fetch 0,4,8,12
        for (int unsigned k = 0; k < 4; k++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("t1_addr", imemaddr, 32'(4 * k));
            chk("t1_valid", {31'b0, valid_out}, 32'h1);
            chk("t1_npc", npc_out, 32'(4 * k + 4));
        end
        // redirect with ihit drops the word at 16 and goes back to 8
        tick(1'b1, 1'b1, 1'b0, 1'b1, 32'h8);
        chk("t1_drop_valid", {31'b0, valid_out}, 32'h0);

        // 2: stall with ihit at pc=8, hold for 3 cycles
        tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("t2_instr0", instr_out, 32'h1000_0008);
        for (int unsigned k = 0; k < 2; k++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            chk("t2_ren", {31'b0, imemREN}, 32'h0);
            chk("t2_instr", instr_out, 32'h1000_0008);
            chk("t2_npc", npc_out, 32'hC);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t2_accept", instr_out, 32'h1000_0008);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t2_next_addr", imemaddr, 32'hC);

        // 3: redirect to 0x40 with request outstanding
        tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        chk("t3_valid", {31'b0, valid_out}, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t3_hold_addr", imemaddr, 32'hC);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t3_discard", {31'b0, valid_out}, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t3_new_addr", imemaddr, 32'h40);
        chk("t3_instr", instr_out, 32'h1000_0040);

        // 4: second redirect while squashing wins
        tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h80);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t4_old_addr", imemaddr, 32'h44);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t4_addr", imemaddr, 32'h80);

        // 5: accept HALT at 0x10, then redirect out of it
        halt_at = 32'h10;
        tick(1'b1, 1'b1, 1'b0, 1'b1, 32'h10);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t5_halt_word", instr_out, 32'hFC00_0000);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t5_halted", {31'b0, halted}, 32'h1);
        chk("t5_ren", {31'b0, imemREN}, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t5_ren2", {31'b0, imemREN}, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h20);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t5_unhalt", {31'b0, halted}, 32'h0);
        chk("t5_addr", imemaddr, 32'h20);
        halt_at = 32'hFFFF_FFFF;

        // 6: reset while in HOLD
        tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("t6_hold_ren", {31'b0, imemREN}, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("t6_rst_valid", {31'b0, valid_out}, 32'h0);
        chk("t6_rst_instr", instr_out, 32'h0);
        chk("t6_rst_npc", npc_out, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t6_addr", imemaddr, 32'h0);
        chk("t6_ren", {31'b0, imemREN}, 32'h1);

        // PC wrap at the top of the address space
        tick(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_npc", npc_out, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr", imemaddr, 32'h0);

        // randomized traffic
        rand_halts = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            logic        r_rst, r_ihit, r_stall, r_redir;
            logic [31:0] r_pc;
            r_rst   = ($urandom_range(0, 99) != 0);
            r_ihit  = ($urandom_range(0, 2) != 0);
            r_stall = ($urandom_range(0, 2) == 0);
            r_redir = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       r_pc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
                1:       r_pc = $urandom;
                default: r_pc = $urandom & 32'h0000_0FFC;
            endcase
            tick(r_rst, r_ihit, r_stall, r_redir, r_pc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
